xvid_bus_master: RTL and testbench
==================================

Name: xvid_bus_master

Overview:
- Host-side initiator for the Xosera 8-bit CPU register bus. It turns one 16-bit register request into two byte bus cycles: even byte with bytesel=0, then odd byte with bytesel=1.
- Timing of each byte cycle is set by parameters.
- Used by bench models, a UART-to-bus bridge, and on-board test logic that drive the Xosera register file (reg 0x0–0xF) the same way an external CPU does.

Parameters:
- SETUP_CYC, 1, cycles the address, RnW and write data are stable with bus_cs_n_o=1 before the strobe (≥1).
- STROBE_CYC, 3, cycles bus_cs_n_o=0 per byte (≥1).
- HOLD_CYC, 1, cycles the address and data stay held with bus_cs_n_o=1 after the strobe (≥1).

Ports:
- clk  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  request strobe
- req_ready_o  out  1  block idle; request accepted when valid&ready
- req_rnw_i  in  1  1=read (RnW_READ), 0=write (RnW_WRITE)
- req_reg_i  in  4  register number (XVID_AUX_ADDR..XVID_UNUSED_2)
- req_wdata_i  in  16  write data; [15:8] even byte, [7:0] odd byte
- rsp_valid_o  out  1  one-cycle pulse: access complete
- rsp_rdata_o  out  16  last read word
- bus_cs_n_o  out  1  chip select (cs_ENABLED=0)
- bus_rd_nwr_o  out  1  RnW to Xosera
- bus_reg_num_o  out  4  register number
- bus_bytesel_o  out  1  0=even/high byte, 1=odd/low byte
- bus_data_o  out  8  write byte
- bus_data_oe_o  out  1  drive bus_data_o (writes only, whole byte phase)
- bus_data_i  in  8  read byte from Xosera

Behaviour:
- Reset values:
  - req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0.
  - bus_cs_n_o=1, bus_rd_nwr_o=1, bus_reg_num_o=0, bus_bytesel_o=0, bus_data_o=0, bus_data_oe_o=0.
- Request capture: on accept, latch rnw, reg and wdata. Input changes after accept are ignored.
- FSM states: IDLE, SETUP, STROBE, HOLD. Bytes are tracked by a byte flag (0=even, 1=odd) and a down-counter sized for max(SETUP_CYC, STROBE_CYC, HOLD_CYC).
  - IDLE→SETUP on accept, with byte=0.
  - SETUP lasts SETUP_CYC cycles, then →STROBE.
  - STROBE lasts STROBE_CYC cycles, then →HOLD.
  - HOLD lasts HOLD_CYC cycles. Then →SETUP with byte=1 if byte=0; →IDLE if byte=1.
- Outputs by state:
  - bus_cs_n_o=0 only in STROBE.
  - In SETUP/STROBE/HOLD: reg_num, rd_nwr and bytesel are driven from the latched request.
  - For writes, bus_data_o = byte ? wdata[7:0] : wdata[15:8], and bus_data_oe_o=1.
  - In IDLE: bus_cs_n_o=1, bus_data_oe_o=0. reg_num, bytesel and data keep their last values; rd_nwr returns to 1.
- Read sampling: bus_data_i is registered at the clock edge that ends the final STROBE cycle. The even byte goes to rsp_rdata_o[15:8], the odd byte to [7:0]. rsp_rdata_o updates atomically (both bytes) in the same cycle rsp_valid_o pulses. Writes leave rsp_rdata_o unchanged.
- Latency:
  - Access length is 2×(SETUP_CYC+STROBE_CYC+HOLD_CYC) cycles, counted from the cycle after accept to the last HOLD cycle. With defaults this is 10 cycles.
  - rsp_valid_o pulses in the first IDLE cycle after the last HOLD cycle.
  - req_ready_o=1 in that same cycle, so back-to-back requests are allowed. Minimum period is 11 cycles with defaults.
- Odd-byte ordering is mandatory: Xosera triggers side effects on the odd-byte write. The odd byte is never issued before the even byte, and the even byte is never skipped.
- Reset mid-operation (any state): the next edge forces all reset values and drops cs and oe immediately. No rsp_valid_o pulse is issued for the aborted access.
- req_valid_i while busy: ignored (ready=0); no queuing.

Test Plan:
- Write reg 0x3 (XVID_WR_ADDR) data 0x1234, defaults:
  - bytesel=0, data 0x12, cs low cycles 2–4 after accept.
  - bytesel=1, data 0x34, cs low cycles 7–9.
  - oe=1 cycles 1–10, rsp_valid at cycle 11.
- Read reg 0x4 with a bench responder returning 0xAB (even) / 0xCD (odd):
  - rd_nwr=1 and oe=0 throughout.
  - rsp_rdata=0xABCD with rsp_valid at cycle 11.
  - A bus_data_i change during SETUP has no effect on the result.
- Back-to-back: write 0x0 data 0x0003, with a read of 0x6 presented during the rsp_valid cycle:
  - Read accepted in that same cycle, no idle gap.
  - Exactly 4 cs-low pulses in total, each 3 cycles wide.
- Parameter sweep SETUP/STROBE/HOLD = 2/1/3:
  - Cycle spacing matches exactly.
  - Access length 12 cycles, rsp_valid at cycle 13.
- Assert reset_i during the odd-byte STROBE of a write:
  - Next cycle cs_n=1, oe=0, ready=1.
  - No rsp_valid pulse.
  - A subsequent read completes normally.
- req_valid held high while busy, with changing req_wdata:
  - Only the first request is issued.
  - The data driven on the bus is the latched data.

Source files
------------

// File: rtl/xvid_bus_master.sv
// Xosera 8-bit register bus initiator: splits one 16-bit register access into
// an even-byte then an odd-byte bus cycle with parameterised setup/strobe/hold.
module xvid_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rnw_i,
  input  logic [3:0]  req_reg_i,
  input  logic [15:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic [3:0]  bus_reg_num_o,
  output logic        bus_bytesel_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  input  logic [7:0]  bus_data_i
);

  localparam int MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_CYC = (MAX_SS > HOLD_CYC) ? MAX_SS : HOLD_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            byte_q, byte_d;
  logic            accept, sample, finish;

  logic            rnw_q;
  logic [3:0]      reg_q;
  logic [15:0]     wdata_q;
  logic [7:0]      even_q, odd_q;
  logic            rsp_valid_q;
  logic [15:0]     rdata_q;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      byte_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    accept  = 1'b0;
    sample  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
          byte_d  = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = CW'(STROBE_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          sample  = 1'b1;
          state_d = HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          if (byte_q) begin
            state_d = IDLE;
            finish  = 1'b1;
          end else begin
            state_d = SETUP;
            byte_d  = 1'b1;
            cnt_d   = CW'(SETUP_CYC - 1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read bytes are staged separately so rsp_rdata_o only changes with rsp_valid_o.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      rnw_q       <= 1'b1;
      reg_q       <= '0;
      wdata_q     <= '0;
      even_q      <= '0;
      odd_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rsp_valid_q <= finish;
      if (accept) begin
        rnw_q   <= req_rnw_i;
        reg_q   <= req_reg_i;
        wdata_q <= req_wdata_i;
      end
      if (sample && rnw_q) begin
        if (byte_q) odd_q  <= bus_data_i;
        else        even_q <= bus_data_i;
      end
      if (finish && rnw_q) rdata_q <= {even_q, odd_q};
    end
  end

  always_comb begin
    req_ready_o   = (state_q == IDLE);
    rsp_valid_o   = rsp_valid_q;
    rsp_rdata_o   = rdata_q;
    bus_cs_n_o    = (state_q != STROBE);
    bus_rd_nwr_o  = (state_q == IDLE) ? 1'b1 : rnw_q;
    bus_reg_num_o = reg_q;
    bus_bytesel_o = byte_q;
    bus_data_o    = byte_q ? wdata_q[7:0] : wdata_q[15:8];
    bus_data_oe_o = (state_q != IDLE) && !rnw_q;
  end

endmodule

// File: tb/tb_xvid_bus_master.sv
// Directed bench for xvid_bus_master: default-timing instance plus a 2/1/3 instance,
// per-cycle bus checks from a small timing model, and a bus-side read responder.
module tb_xvid_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid;
  logic        sel;
  logic        req_rnw;
  logic [3:0]  req_reg;
  logic [15:0] req_wdata;
  logic [7:0]  rd_hi, rd_lo;
  logic [7:0]  junk = 8'h00;

  logic        ready0, rspv0, cs0, rdnwr0, bsel0, oe0;
  logic [15:0] rdata0;
  logic [3:0]  regn0;
  logic [7:0]  dout0, din0;
  logic        ready1, rspv1, cs1, rdnwr1, bsel1, oe1;
  logic [15:0] rdata1;
  logic [3:0]  regn1;
  logic [7:0]  dout1, din1;

  // Responder: valid byte only while strobed, noise otherwise.
  assign din0 = cs0 ? junk : (bsel0 ? rd_lo : rd_hi);
  assign din1 = cs1 ? junk : (bsel1 ? rd_lo : rd_hi);
  always @(negedge clk) junk <= 8'($urandom);

  xvid_bus_master dut0 (
    .clk(clk), .reset_i(reset),
    .req_valid_i(req_valid & ~sel), .req_ready_o(ready0),
    .req_rnw_i(req_rnw), .req_reg_i(req_reg), .req_wdata_i(req_wdata),
    .rsp_valid_o(rspv0), .rsp_rdata_o(rdata0),
    .bus_cs_n_o(cs0), .bus_rd_nwr_o(rdnwr0), .bus_reg_num_o(regn0),
    .bus_bytesel_o(bsel0), .bus_data_o(dout0), .bus_data_oe_o(oe0),
    .bus_data_i(din0)
  );

  xvid_bus_master #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3)) dut1 (
    .clk(clk), .reset_i(reset),
    .req_valid_i(req_valid & sel), .req_ready_o(ready1),
    .req_rnw_i(req_rnw), .req_reg_i(req_reg), .req_wdata_i(req_wdata),
    .rsp_valid_o(rspv1), .rsp_rdata_o(rdata1),
    .bus_cs_n_o(cs1), .bus_rd_nwr_o(rdnwr1), .bus_reg_num_o(regn1),
    .bus_bytesel_o(bsel1), .bus_data_o(dout1), .bus_data_oe_o(oe1),
    .bus_data_i(din1)
  );

  // {ready, rsp_valid, cs_n, oe, rd_nwr, bytesel, reg_num, data}
  logic [17:0] m_vec;
  logic [15:0] m_rdata;
  always_comb begin
    m_vec   = sel ? {ready1, rspv1, cs1, oe1, rdnwr1, bsel1, regn1, dout1}
                  : {ready0, rspv0, cs0, oe0, rdnwr0, bsel0, regn0, dout0};
    m_rdata = sel ? rdata1 : rdata0;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // cs-low pulse monitor on the default instance
  logic mon_en = 1'b0;
  int   run = 0, pulses = 0, badw = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      run <= cs0 ? 0 : run + 1;
      if (cs0 && run != 0) begin
        pulses <= pulses + 1;
        if (run != 3) badw <= badw + 1;
      end
    end
  end

  typedef struct {
    logic        rnw;
    logic [3:0]  rg;
    logic [15:0] wdata;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } vec_t;

  vec_t vecs [5];

  task automatic issue(input string tag, input logic rnw, input logic [3:0] r,
                       input logic [15:0] w);
    req_rnw   = rnw;
    req_reg   = r;
    req_wdata = w;
    req_valid = 1'b1;
    check({tag, "_ready"}, {31'b0, m_vec[17]}, 32'd1);
  endtask

  // Called at the negedge where issue() raised valid; returns at the rsp cycle negedge.
  task automatic track(input string tag, input int s, input int t, input int h,
                       input logic rnw, input logic [3:0] r, input logic [15:0] w,
                       input logic [15:0] exp_rd, input bit hold_valid);
    int          ph;
    int          len;
    int          off;
    int          b;
    logic        strobe;
    logic [17:0] exp;
    logic [17:0] mask;
    ph   = s + t + h;
    len  = 2 * ph;
    mask = rnw ? 18'h3FF00 : 18'h3FFFF;
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= len; k++) begin
      if (hold_valid && k < len) begin
        req_wdata = 16'($urandom);
        req_reg   = 4'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      off    = (k - 1) % ph;
      b      = (k - 1) / ph;
      strobe = (off >= s) && (off < s + t);
      exp    = {1'b0, 1'b0, ~strobe, ~rnw, rnw, (b == 1), r,
                (b == 1) ? w[7:0] : w[15:8]};
      check($sformatf("%s_c%0d", tag, k), {14'b0, m_vec & mask}, {14'b0, exp & mask});
      @(negedge clk);
    end
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, r, w[7:0]};
    check({tag, "_rsp"}, {14'b0, m_vec & mask}, {14'b0, exp & mask});
    check({tag, "_rdata"}, {16'b0, m_rdata}, {16'b0, exp_rd});
  endtask

  logic [15:0] last_rd;
  int          stray;

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    sel       = 1'b0;
    req_rnw   = 1'b0;
    req_reg   = '0;
    req_wdata = '0;
    rd_hi     = '0;
    rd_lo     = '0;
    vecs[0] = '{rnw: 1'b0, rg: 4'h3, wdata: 16'h1234, hi: 8'h00, lo: 8'h00};
    vecs[1] = '{rnw: 1'b1, rg: 4'h4, wdata: 16'h0000, hi: 8'hAB, lo: 8'hCD};
    vecs[2] = '{rnw: 1'b0, rg: 4'hF, wdata: 16'hFF00, hi: 8'h00, lo: 8'h00};
    vecs[3] = '{rnw: 1'b1, rg: 4'hA, wdata: 16'h5555, hi: 8'h00, lo: 8'hFF};
    vecs[4] = '{rnw: 1'b0, rg: 4'h8, wdata: 16'h5AA5, hi: 8'h00, lo: 8'h00};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = (i == 1);
      #1;
      check($sformatf("reset_state%0d", i), {14'b0, m_vec},
            {14'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00});
      check($sformatf("reset_rdata%0d", i), {16'b0, m_rdata}, 32'd0);
    end
    sel   = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    last_rd = '0;
    for (int i = 0; i < 5; i++) begin
      rd_hi = vecs[i].hi;
      rd_lo = vecs[i].lo;
      if (vecs[i].rnw) last_rd = {vecs[i].hi, vecs[i].lo};
      issue($sformatf("v%0d", i), vecs[i].rnw, vecs[i].rg, vecs[i].wdata);
      track($sformatf("v%0d", i), 1, 3, 1, vecs[i].rnw, vecs[i].rg, vecs[i].wdata,
            last_rd, 1'b0);
      @(negedge clk);
    end

    // Back-to-back: read presented in the rsp_valid cycle of a write.
    mon_en = 1'b1;
    issue("b2b_w", 1'b0, 4'h0, 16'h0003);
    track("b2b_w", 1, 3, 1, 1'b0, 4'h0, 16'h0003, last_rd, 1'b0);
    rd_hi = 8'h5E;
    rd_lo = 8'h71;
    last_rd = 16'h5E71;
    issue("b2b_r", 1'b1, 4'h6, 16'h0000);
    track("b2b_r", 1, 3, 1, 1'b1, 4'h6, 16'h0000, last_rd, 1'b0);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    @(negedge clk);
    check("b2b_pulses", pulses, 32'd4);
    check("b2b_bad_width", badw, 32'd0);

    // Valid held high while busy with changing inputs.
    issue("hold", 1'b0, 4'h9, 16'hC3A5);
    track("hold", 1, 3, 1, 1'b0, 4'h9, 16'hC3A5, last_rd, 1'b1);
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_vec[15] !== 1'b1 || m_vec[17] !== 1'b1) stray++;
    end
    check("hold_no_second", stray, 32'd0);

    // Timing sweep on the 2/1/3 instance.
    sel = 1'b1;
    #1;
    issue("sw_w", 1'b0, 4'h7, 16'h8421);
    track("sw_w", 2, 1, 3, 1'b0, 4'h7, 16'h8421, 16'h0000, 1'b0);
    @(negedge clk);
    rd_hi = 8'h3C;
    rd_lo = 8'hA9;
    issue("sw_r", 1'b1, 4'hB, 16'h0000);
    track("sw_r", 2, 1, 3, 1'b1, 4'hB, 16'h0000, 16'h3CA9, 1'b0);
    @(negedge clk);
    sel = 1'b0;
    #1;

    // Reset during the odd-byte strobe of a write.
    issue("rst", 1'b0, 4'h2, 16'hBEEF);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_pre", {30'b0, m_vec[15], m_vec[12]}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_post", {14'b0, m_vec},
          {14'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00});
    reset = 1'b0;
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (m_vec[16] !== 1'b0 || m_vec[15] !== 1'b1) stray++;
    end
    check("rst_no_rsp", stray, 32'd0);
    check("rst_rdata", {16'b0, m_rdata}, 32'd0);

    rd_hi = 8'h9C;
    rd_lo = 8'h3E;
    issue("post_rst", 1'b1, 4'h4, 16'h0000);
    track("post_rst", 1, 3, 1, 1'b1, 4'h4, 16'h0000, 16'h9C3E, 1'b0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
